// File: rtl/seg_scan_driver.sv
// Memory-mapped 4-digit seven-segment scanner: a DATA/CTRL register pair on the
// CPU bus, plus a time-multiplexed hex decoder driving active-low anodes and segments.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter logic [31:0] BASE_ADDR = 32'h40000014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [7:0]  BCD,
    output logic [3:0]  ano
);

    localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CTRL_W  = 5;
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  div_cnt;
    logic [1:0]        digit_idx;

    logic        sel_data;
    logic        sel_ctrl;
    logic        enable;
    logic [3:0]  dp_mask;
    logic [3:0]  nibble;
    logic [3:0]  ano_nxt;
    logic [7:0]  bcd_nxt;
    logic [15:0] unused_wd_hi;

    assign sel_data     = (Address == BASE_ADDR);
    assign sel_ctrl     = (Address == CTRL_ADDR);
    assign enable       = ctrl_q[0];
    assign dp_mask      = ctrl_q[4:1];
    assign unused_wd_hi = Write_data[31:16];

    // Active-low hex glyph, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Bus register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            ctrl_q <= CTRL_W'(1);
        end else if (MemWrite) begin
            if (sel_data) begin
                data_q <= Write_data[DATA_W-1:0];
            end
            if (sel_ctrl) begin
                ctrl_q <= Write_data[CTRL_W-1:0];
            end
        end
    end

    // Pre-write values are returned on a same-cycle read/write
    always_comb begin
        Read_data = 32'h0;
        if (MemRead && sel_data) begin
            Read_data = {16'h0, data_q};
        end else if (MemRead && sel_ctrl) begin
            Read_data = {27'h0, ctrl_q};
        end
    end

    // Scan divider and digit index; held at zero while disabled so re-enable starts fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (!enable) begin
            div_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (div_cnt == CNT_MAX) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            div_cnt   <= div_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nibble  = 4'h0;
        ano_nxt = 4'hF;
        bcd_nxt = 8'hFF;
        case (digit_idx)
            2'd0:    nibble = data_q[3:0];
            2'd1:    nibble = data_q[7:4];
            2'd2:    nibble = data_q[11:8];
            default: nibble = data_q[15:12];
        endcase
        if (enable) begin
            ano_nxt = ~(4'b0001 << digit_idx);
            bcd_nxt = {~dp_mask[digit_idx], hex_glyph(nibble)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ano <= 4'hF;
            BCD <= 8'hFF;
        end else begin
            ano <= ano_nxt;
            BCD <= bcd_nxt;
        end
    end

endmodule
